// File: rtl/lcd_write_ctrl.sv
// HD44780-style write-only LCD controller: power-up init, then one timed bus write per accepted 9-bit code.
// Cursor is tracked locally so line wraps are issued automatically after COLS characters.
module lcd_write_ctrl #(
  parameter int POWERUP_CYC  = 750000,
  parameter int SETUP_CYC    = 4,
  parameter int E_PULSE_CYC  = 12,
  parameter int HOLD_CYC     = 4,
  parameter int CMD_WAIT_CYC = 2000,
  parameter int CLR_WAIT_CYC = 82000,
  parameter int COLS         = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       code_valid,
  input  logic [8:0] code,
  output logic       code_ready,
  output logic       init_done,
  output logic       lcd_rs,
  output logic       lcd_rw,
  output logic       lcd_en,
  output logic [7:0] lcd_data,
  output logic       lcd_on
);

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  localparam int MAXC = max2(max2(max2(POWERUP_CYC, SETUP_CYC), max2(E_PULSE_CYC, HOLD_CYC)),
                             max2(CMD_WAIT_CYC, CLR_WAIT_CYC));
  localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;

  // Counters load N-1 on entry and exit at zero, so a zero-length phase still takes one cycle.
  function automatic logic [CW-1:0] ld(input int n);
    return (n > 1) ? CW'(n - 1) : '0;
  endfunction

  localparam logic [CW-1:0] PWR_LD   = ld(POWERUP_CYC);
  localparam logic [CW-1:0] SETUP_LD = ld(SETUP_CYC);
  localparam logic [CW-1:0] PULSE_LD = ld(E_PULSE_CYC);
  localparam logic [CW-1:0] HOLD_LD  = ld(HOLD_CYC);
  localparam logic [CW-1:0] CMD_LD   = ld(CMD_WAIT_CYC);
  localparam logic [CW-1:0] CLR_LD   = ld(CLR_WAIT_CYC);

  localparam logic [2:0] S_PWRUP = 3'd0;
  localparam logic [2:0] S_INIT  = 3'd1;
  localparam logic [2:0] S_SETUP = 3'd2;
  localparam logic [2:0] S_PULSE = 3'd3;
  localparam logic [2:0] S_HOLD  = 3'd4;
  localparam logic [2:0] S_WAIT  = 3'd5;
  localparam logic [2:0] S_IDLE  = 3'd6;
  localparam logic [2:0] S_WRAP  = 3'd7;

  function automatic logic [7:0] init_rom(input logic [2:0] i);
    case (i)
      3'd4:    return 8'h0C;
      3'd5:    return 8'h01;
      3'd6:    return 8'h06;
      default: return 8'h38;
    endcase
  endfunction

  logic [2:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    idx_q, idx_d;
  logic          init_done_q, init_done_d;
  logic          line_q, line_d;
  logic [5:0]    col_q, col_d;
  logic [8:0]    code_q, code_d;
  logic          rs_q, rs_d;
  logic [7:0]    data_q, data_d;
  logic          en_q, rdy_q;

  logic cnt_done, is_clr, wrap_hit;

  assign cnt_done = (cnt_q == '0);
  assign is_clr   = !rs_q && (data_q == 8'h01 || data_q == 8'h02 || data_q == 8'h03);
  assign wrap_hit = ({1'b0, col_q} + 7'd1) >= 7'(COLS);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_done ? cnt_q : cnt_q - CW'(1);
    idx_d       = idx_q;
    init_done_d = init_done_q;
    line_d      = line_q;
    col_d       = col_q;
    code_d      = code_q;
    rs_d        = rs_q;
    data_d      = data_q;
    case (state_q)
      S_PWRUP: if (cnt_done) state_d = S_INIT;
      S_INIT: begin
        if (init_done_q) begin
          rs_d   = code_q[8];
          data_d = code_q[7:0];
        end else begin
          rs_d   = 1'b0;
          data_d = init_rom(idx_q);
        end
        state_d = S_SETUP;
        cnt_d   = SETUP_LD;
      end
      S_WRAP: begin
        rs_d    = 1'b0;
        data_d  = line_q ? 8'h80 : 8'hC0;
        state_d = S_SETUP;
        cnt_d   = SETUP_LD;
      end
      S_SETUP: if (cnt_done) begin
        state_d = S_PULSE;
        cnt_d   = PULSE_LD;
      end
      S_PULSE: if (cnt_done) begin
        state_d = S_HOLD;
        cnt_d   = HOLD_LD;
      end
      S_HOLD: if (cnt_done) begin
        state_d = S_WAIT;
        cnt_d   = is_clr ? CLR_LD : CMD_LD;
      end
      S_WAIT: if (cnt_done) begin
        if (rs_q) begin
          col_d = col_q + 6'd1;
        end else if (data_q[7]) begin
          line_d = data_q[6];
          col_d  = data_q[5:0];
        end else if (is_clr) begin
          line_d = 1'b0;
          col_d  = 6'd0;
        end
        if (!init_done_q) begin
          if (idx_q == 3'd6) begin
            init_done_d = 1'b1;
            line_d      = 1'b0;
            col_d       = 6'd0;
            state_d     = S_IDLE;
          end else begin
            idx_d   = idx_q + 3'd1;
            state_d = S_INIT;
          end
        end else if (rs_q && wrap_hit) begin
          state_d = S_WRAP;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: if (code_valid) begin
        code_d  = code;
        state_d = S_INIT;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_PWRUP;
      cnt_q       <= PWR_LD;
      idx_q       <= 3'd0;
      init_done_q <= 1'b0;
      line_q      <= 1'b0;
      col_q       <= 6'd0;
      code_q      <= 9'd0;
      rs_q        <= 1'b0;
      data_q      <= 8'h00;
      en_q        <= 1'b0;
      rdy_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      init_done_q <= init_done_d;
      line_q      <= line_d;
      col_q       <= col_d;
      code_q      <= code_d;
      rs_q        <= rs_d;
      data_q      <= data_d;
      en_q        <= (state_d == S_PULSE);
      rdy_q       <= (state_d == S_IDLE);
    end
  end

  assign code_ready = rdy_q;
  assign init_done  = init_done_q;
  assign lcd_rs     = rs_q;
  assign lcd_rw     = 1'b0;
  assign lcd_en     = en_q;
  assign lcd_data   = data_q;
  assign lcd_on     = 1'b1;

endmodule

// File: tb/tb_lcd_write_ctrl.sv
// Bench for lcd_write_ctrl: a queue-of-expected-cycles model built from write timings and cursor rules,
// compared every cycle, plus literal checks on init order, strobe timing, wraps and reset.
module tb_lcd_write_ctrl;
  localparam int PWR = 20, SU = 2, EP = 3, HO = 2, CMDW = 10, CLRW = 40, COLS = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       code_valid = 1'b0;
  logic [8:0] code = 9'd0;
  logic       code_ready, init_done, lcd_rs, lcd_rw, lcd_en, lcd_on;
  logic [7:0] lcd_data;

  lcd_write_ctrl #(
    .POWERUP_CYC(PWR), .SETUP_CYC(SU), .E_PULSE_CYC(EP), .HOLD_CYC(HO),
    .CMD_WAIT_CYC(CMDW), .CLR_WAIT_CYC(CLRW), .COLS(COLS)
  ) dut (
    .clk(clk), .rst_n(rst_n), .code_valid(code_valid), .code(code),
    .code_ready(code_ready), .init_done(init_done), .lcd_rs(lcd_rs), .lcd_rw(lcd_rw),
    .lcd_en(lcd_en), .lcd_data(lcd_data), .lcd_on(lcd_on)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic       en;
    logic       rs;
    logic [7:0] dat;
    logic       rdy;
    logic       idn;
  } exp_t;

  exp_t       expq[$];
  logic       m_rs, m_init;
  logic [7:0] m_dat;
  int         m_line, m_col;
  int         acc_cnt = 0;
  bit         need_init = 1'b1;
  logic [8:0] init_exp[7];

  function automatic int atleast1(input int n);
    return (n < 1) ? 1 : n;
  endfunction

  task automatic push_n(input int n, input logic en);
    exp_t e;
    e.en = en; e.rs = m_rs; e.dat = m_dat; e.rdy = 1'b0; e.idn = m_init;
    for (int i = 0; i < n; i++) expq.push_back(e);
  endtask

  // One bus write: a load cycle holding the old bus, then setup, strobe, hold and the settle wait.
  task automatic push_write(input logic rs, input logic [7:0] b);
    int w;
    w = (!rs && b >= 8'h01 && b <= 8'h03) ? CLRW : CMDW;
    push_n(1, 1'b0);
    m_rs = rs; m_dat = b;
    push_n(atleast1(SU), 1'b0);
    push_n(atleast1(EP), 1'b1);
    push_n(atleast1(HO), 1'b0);
    push_n(atleast1(w), 1'b0);
  endtask

  task automatic model_init();
    expq.delete();
    m_rs = 1'b0; m_dat = 8'h00; m_init = 1'b0; m_line = 0; m_col = 0;
    push_n(atleast1(PWR), 1'b0);
    for (int i = 0; i < 7; i++) push_write(1'b0, init_exp[i][7:0]);
    m_init = 1'b1;
  endtask

  task automatic model_accept(input logic [8:0] c);
    logic [7:0] b;
    b = c[7:0];
    push_write(c[8], b);
    if (c[8]) begin
      m_col++;
      if (m_col >= COLS) begin
        push_write(1'b0, (m_line == 0) ? 8'hC0 : 8'h80);
        m_line = 1 - m_line;
        m_col = 0;
      end
    end else if (b[7]) begin
      m_line = b[6]; m_col = b[5:0];
    end else if (b >= 8'h01 && b <= 8'h03) begin
      m_line = 0; m_col = 0;
    end
  endtask

  // Per-cycle compare against the model; also decides when a transfer happens.
  always @(negedge clk) begin
    exp_t e;
    checks++;
    if (!rst_n) begin
      need_init = 1'b1;
      expq.delete();
      if (lcd_en !== 1'b0 || lcd_rs !== 1'b0 || lcd_data !== 8'h00 || code_ready !== 1'b0 ||
          init_done !== 1'b0 || lcd_rw !== 1'b0 || lcd_on !== 1'b1) begin
        errors++;
        $display("FAIL reset_values t=%0t: en=%b rs=%b data=%h rdy=%b init=%b rw=%b on=%b, want 0 0 00 0 0 0 1",
                 $time, lcd_en, lcd_rs, lcd_data, code_ready, init_done, lcd_rw, lcd_on);
      end
    end else begin
      if (need_init) begin
        model_init();
        need_init = 1'b0;
      end
      if (expq.size() > 0) e = expq.pop_front();
      else begin
        e.en = 1'b0; e.rs = m_rs; e.dat = m_dat; e.rdy = 1'b1; e.idn = m_init;
      end
      if (lcd_en !== e.en || lcd_rs !== e.rs || lcd_data !== e.dat || code_ready !== e.rdy ||
          init_done !== e.idn || lcd_rw !== 1'b0 || lcd_on !== 1'b1) begin
        errors++;
        $display("FAIL cycle_compare t=%0t: dut en=%b rs=%b data=%h rdy=%b init=%b rw=%b on=%b, model en=%b rs=%b data=%h rdy=%b init=%b",
                 $time, lcd_en, lcd_rs, lcd_data, code_ready, init_done, lcd_rw, lcd_on,
                 e.en, e.rs, e.dat, e.rdy, e.idn);
      end
      if (e.rdy && code_valid) begin
        model_accept(code);
        acc_cnt++;
      end
    end
  end

  // Bus monitor: logs each strobe's RS/data, high width and preceding low gap.
  logic [8:0] wr_log[$];
  int         wid_log[$];
  int         gap_log[$];
  int         since_rst, hi_cnt, lo_cnt, first_en;
  logic       prev_en;

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_en = 1'b0; since_rst = 0; hi_cnt = 0; lo_cnt = 0; first_en = 0;
    end else begin
      since_rst++;
      if (lcd_en) begin
        if (!prev_en) begin
          wr_log.push_back({lcd_rs, lcd_data});
          gap_log.push_back(lo_cnt);
          if (first_en == 0) first_en = since_rst;
          hi_cnt = 0;
        end
        hi_cnt++;
      end else begin
        if (prev_en) begin
          wid_log.push_back(hi_cnt);
          lo_cnt = 0;
        end
        lo_cnt++;
      end
      prev_en = lcd_en;
    end
  end

  task automatic chk(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h), want %0d (0x%0h)", name, got, got, want, want);
    end
  endtask

  function automatic int log_at(input int i);
    return (wr_log.size() > i) ? int'(wr_log[i]) : -1;
  endfunction

  function automatic int wid_at(input int i);
    return (wid_log.size() > i) ? wid_log[i] : -1;
  endfunction

  function automatic int gap_at(input int i);
    return (gap_log.size() > i) ? gap_log[i] : -1;
  endfunction

  task automatic clear_logs();
    wr_log.delete(); wid_log.delete(); gap_log.delete();
  endtask

  task automatic send(input logic [8:0] c);
    int start, n;
    start = acc_cnt; code = c; code_valid = 1'b1; n = 0;
    while (acc_cnt == start && n < 500) begin
      @(posedge clk); #1; n++;
    end
    checks++;
    if (acc_cnt == start) begin
      errors++;
      $display("FAIL send_timeout: code %h not accepted in %0d cycles, want accept", c, n);
    end
  endtask

  task automatic wait_ready(input string name);
    int n;
    n = 0;
    while (!code_ready && n < 2000) begin
      @(posedge clk); #1; n++;
    end
    chk(name, int'(code_ready), 1);
  endtask

  task automatic wait_init();
    int n;
    n = 0;
    while (!init_done && n < 3000) begin
      @(posedge clk); #1; n++;
    end
    chk("init_done_timeout", int'(init_done), 1);
  endtask

  function automatic logic [8:0] rand_code();
    int r;
    r = $urandom_range(0, 9);
    if (r < 6) return {1'b1, 8'($urandom_range(32'h20, 32'h7E))};
    if (r == 6) return {1'b0, 8'($urandom_range(1, 3))};
    if (r == 7) return {1'b0, 1'b1, 1'($urandom_range(0, 1)), 6'($urandom_range(0, 7))};
    if (r == 8) return {1'b0, 8'($urandom_range(4, 127))};
    return {1'b0, 2'b10, 6'($urandom_range(0, 63))};
  endfunction

  task automatic send_chars(input int n, input logic [7:0] base);
    for (int i = 0; i < n; i++) send({1'b1, base + 8'(i)});
    code_valid = 1'b0;
    wait_ready("wrap_ready");
  endtask

  initial begin
    int n;
    init_exp[0] = 9'h038; init_exp[1] = 9'h038; init_exp[2] = 9'h038; init_exp[3] = 9'h038;
    init_exp[4] = 9'h00C; init_exp[5] = 9'h001; init_exp[6] = 9'h006;

    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;

    // Power-up init sequence
    wait_init();
    chk("init_writes", wr_log.size(), 7);
    for (int i = 0; i < 7; i++) begin
      chk("init_byte", log_at(i), int'(init_exp[i]));
      chk("init_en_width", wid_at(i), 3);
    end
    chk("first_en_cycle", first_en, 24);
    chk("gap_after_38", gap_at(1), 15);
    chk("gap_after_01", gap_at(6), 45);
    chk("ready_after_init", int'(code_ready), 1);

    // Single character: latency, strobe width, return to ready
    @(posedge clk); #1;
    clear_logs();
    send(9'h141);
    code_valid = 1'b0;
    n = 0;
    while (!lcd_en && n < 50) begin @(posedge clk); #1; n++; end
    chk("accept_to_en", n, 3);
    n = 0;
    while (lcd_en && n < 50) begin @(posedge clk); #1; n++; end
    chk("en_width", n, 3);
    n = 0;
    while (!code_ready && n < 100) begin @(posedge clk); #1; n++; end
    chk("en_fall_to_ready", n, 12);
    chk("char_write", log_at(0), 9'h141);

    // Wraps line 1 -> 2 -> 1 with code_valid held across busy periods
    send(9'h080); code_valid = 1'b0; wait_ready("addr_ready");
    clear_logs();
    send_chars(4, 8'h41);
    chk("wrap1_count", wr_log.size(), 5);
    chk("wrap1_cmd", log_at(4), 9'h0C0);
    chk("wrap1_third", log_at(2), 9'h143);
    clear_logs();
    send_chars(4, 8'h61);
    chk("wrap2_count", wr_log.size(), 5);
    chk("wrap2_cmd", log_at(4), 9'h080);

    // Enter to line 2, then clear back to line 1
    send(9'h0C0); code_valid = 1'b0; wait_ready("enter_ready");
    clear_logs();
    send_chars(4, 8'h30);
    chk("enter_wrap_cmd", log_at(4), 9'h080);
    send(9'h001); code_valid = 1'b0; wait_ready("clear_ready");
    clear_logs();
    send_chars(4, 8'h30);
    chk("clear_wrap_cmd", log_at(4), 9'h0C0);

    // Set address past the last column: next character wraps immediately
    send(9'h0C6); code_valid = 1'b0; wait_ready("far_ready");
    clear_logs();
    send_chars(1, 8'h5A);
    chk("far_wrap_cmd", log_at(1), 9'h080);

    // Idle with no valid: bus stays quiet
    clear_logs();
    repeat (30) @(posedge clk);
    #1;
    chk("idle_quiet", wr_log.size(), 0);

    // Randomized traffic
    for (int k = 0; k < 150; k++) begin
      int gap;
      gap = $urandom_range(0, 3);
      if (gap > 0) begin
        code_valid = 1'b0;
        repeat (gap) begin @(posedge clk); #1; end
      end
      send(rand_code());
    end
    code_valid = 1'b0;
    wait_ready("random_ready");

    // Reset during the enable pulse
    send(9'h155);
    code_valid = 1'b0;
    n = 0;
    while (!lcd_en && n < 50) begin @(posedge clk); #1; n++; end
    chk("en_before_reset", int'(lcd_en), 1);
    rst_n = 1'b0;
    #1;
    chk("en_async_drop", int'(lcd_en), 0);
    chk("init_done_cleared", int'(init_done), 0);
    @(posedge clk);
    @(posedge clk);
    #2 rst_n = 1'b1;
    wait_init();
    chk("first_en_after_reset", first_en, 24);

    for (int k = 0; k < 20; k++) send(rand_code());
    code_valid = 1'b0;
    wait_ready("final_ready");
    repeat (5) @(posedge clk);
    #1;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
